hwce_sop_acc_norm: RTL



---
 rtl/hwce_sop_acc_norm.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hwce_sop_acc_norm.sv
// Accumulate/normalize stage behind the SoP adder.
// Sums acc_len partial sums into one pixel, adds bias, applies a rounded
// arithmetic right shift by qf, saturates to OUT_WIDTH, optionally applies
// ReLU, and hands the pixel to write-back over a valid/ready stream.
module hwce_sop_acc_norm #(
  parameter int SUM_WIDTH = 37,
  parameter int CNT_WIDTH = 8,
  parameter int ACC_WIDTH = 45,
  parameter int OUT_WIDTH = 16,
  parameter int QF_WIDTH  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_i,
  input  logic        [CNT_WIDTH-1:0] acc_len_i,
  input  logic        [QF_WIDTH-1:0]  qf_i,
  input  logic signed [OUT_WIDTH-1:0] bias_i,
  input  logic                        relu_en_i,
  input  logic signed [SUM_WIDTH-1:0] sum_i,
  input  logic                        sum_valid_i,
  output logic                        sum_ready_o,
  output logic signed [OUT_WIDTH-1:0] out_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        sat_o,
  output logic                        busy_o
);

  // Two guard bits above the accumulator absorb the shifted bias and rounding term.
  localparam int TW = ACC_WIDTH + 2;
  localparam logic signed [TW-1:0] MAXV = (TW'(1) <<< (OUT_WIDTH - 1)) - TW'(1);
  localparam logic signed [TW-1:0] MINV = -(TW'(1) <<< (OUT_WIDTH - 1));

  typedef enum logic [1:0] {ACC, NORM, OUT} state_t;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc_p0;
  logic        [CNT_WIDTH-1:0]  cnt;
  logic        [CNT_WIDTH-1:0]  len_q;
  logic        [QF_WIDTH-1:0]   qf_q;
  logic signed [OUT_WIDTH-1:0]  bias_q;
  logic                         relu_q;
  logic signed [OUT_WIDTH-1:0]  out_p1;
  logic                         vld_p1;
  logic                         sat_q;

  logic        [CNT_WIDTH-1:0]  len_in;
  logic        [CNT_WIDTH-1:0]  len_cur;
  logic signed [TW-1:0]         t_p0;
  logic signed [TW-1:0]         r_p0;
  logic signed [OUT_WIDTH-1:0]  pix_p0;
  logic                         clamp_p0;

  // Adds half an LSB of the output grid, then arithmetic shift by qf.
  function automatic logic signed [TW-1:0] round_shift(input logic signed [TW-1:0] t,
                                                       input logic [QF_WIDTH-1:0] qf);
    logic signed [TW-1:0] rnd;
    rnd = (qf != '0) ? (TW'(1) <<< (qf - 1'b1)) : '0;
    return (t + rnd) >>> qf;
  endfunction

  function automatic logic is_clamped(input logic signed [TW-1:0] r);
    return (r > MAXV) || (r < MINV);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [TW-1:0] r);
    logic signed [TW-1:0] c;
    c = (r > MAXV) ? MAXV : ((r < MINV) ? MINV : r);
    return c[OUT_WIDTH-1:0];
  endfunction

  // Length 0 means one partial sum; the first beat uses the live length.
  always_comb begin
    len_in   = (acc_len_i == '0) ? CNT_WIDTH'(1) : acc_len_i;
    len_cur  = (cnt == '0) ? len_in : len_q;
    t_p0     = TW'(acc_p0) + (TW'(bias_q) <<< qf_q);
    r_p0     = round_shift(t_p0, qf_q);
    clamp_p0 = is_clamped(r_p0);
    pix_p0   = saturate(r_p0);
    if (relu_q && (pix_p0 < 0)) pix_p0 = '0;
  end

  assign sum_ready_o = (state == ACC);
  assign busy_o      = (state != ACC) || (cnt != '0);
  assign out_o       = out_p1;
  assign out_valid_o = vld_p1;
  assign sat_o       = sat_q;

  // Control FSM with accumulator and registered output; clear_i overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ACC;
      acc_p0 <= '0;
      cnt    <= '0;
      len_q  <= '0;
      qf_q   <= '0;
      bias_q <= '0;
      relu_q <= 1'b0;
      out_p1 <= '0;
      vld_p1 <= 1'b0;
      sat_q  <= 1'b0;
    end else if (clear_i) begin
      state  <= ACC;
      acc_p0 <= '0;
      cnt    <= '0;
      out_p1 <= '0;
      vld_p1 <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      case (state)
        // Stage p0: accumulate beats; configuration captured on the first one
        ACC: begin
          if (sum_valid_i) begin
            acc_p0 <= acc_p0 + ACC_WIDTH'(sum_i);
            cnt    <= cnt + 1'b1;
            if (cnt == '0) begin
              len_q  <= len_in;
              qf_q   <= qf_i;
              bias_q <= bias_i;
              relu_q <= relu_en_i;
            end
            if (cnt == len_cur - 1'b1) state <= NORM;
          end
        end
        // Stage p1: bias, round, shift, saturate, ReLU into the output register
        NORM: begin
          out_p1 <= pix_p0;
          vld_p1 <= 1'b1;
          if (clamp_p0) sat_q <= 1'b1;
          state  <= OUT;
        end
        OUT: begin
          if (out_ready_i) begin
            vld_p1 <= 1'b0;
            acc_p0 <= '0;
            cnt    <= '0;
            state  <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
